// File: rtl/generic_fifo_lvl.sv
// Valid/grant FIFO of any depth with optional fall-through, a live fill level
// and programmable almost-full / almost-empty flags.
module generic_fifo_lvl #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DATA_DEPTH   = 8,
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned CNT_WIDTH    = $clog2(DATA_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  grant_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  grant_i,
  input  logic [CNT_WIDTH-1:0]  alm_full_thr_i,
  input  logic [CNT_WIDTH-1:0]  alm_empty_thr_i,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  alm_full_o,
  output logic                  alm_empty_o
);

  localparam int unsigned          PtrWidth = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] DepthCnt = CNT_WIDTH'(DATA_DEPTH);
  localparam logic [PtrWidth-1:0]  LastPtr  = PtrWidth'(DATA_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
  logic [PtrWidth-1:0]   push_ptr_q, push_ptr_d;
  logic [PtrWidth-1:0]   pop_ptr_q, pop_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  empty, full;
  logic                  push, pop, bypass, do_write, do_read;

  // Explicit wrap keeps non-power-of-two depths exact.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrWidth'(1);
  endfunction

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == DepthCnt);
    grant_o = !clear_i && !full;
    valid_o = !clear_i && (!empty || (FALL_THROUGH && valid_i));
    push    = valid_i && grant_o;
    pop     = valid_o && grant_i;
    // Empty fall-through transfer passes straight through without touching state.
    bypass   = FALL_THROUGH && empty && push && pop;
    do_write = push && !bypass;
    do_read  = pop && !bypass;
  end

  always_comb begin
    push_ptr_d = push_ptr_q;
    pop_ptr_d  = pop_ptr_q;
    count_d    = count_q;
    if (clear_i) begin
      push_ptr_d = '0;
      pop_ptr_d  = '0;
      count_d    = '0;
    end else begin
      if (do_write) push_ptr_d = ptr_inc(push_ptr_q);
      if (do_read)  pop_ptr_d  = ptr_inc(pop_ptr_q);
      unique case ({do_write, do_read})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_ptr_q <= '0;
      pop_ptr_q  <= '0;
      count_q    <= '0;
    end else begin
      push_ptr_q <= push_ptr_d;
      pop_ptr_q  <= pop_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else if (do_write && !clear_i) begin
      mem_q[push_ptr_q] <= data_i;
    end
  end

  always_comb begin
    data_o      = (FALL_THROUGH && empty) ? data_i : mem_q[pop_ptr_q];
    count_o     = count_q;
    alm_full_o  = (count_q >= alm_full_thr_i);
    alm_empty_o = (count_q <= alm_empty_thr_i);
  end

endmodule

// File: tb/tb_generic_fifo_lvl.sv
// Bench for generic_fifo_lvl: a depth-5 FIFO in normal (index 0) and
// fall-through (index 1) mode, checked against a count model and data queues.
module tb_generic_fifo_lvl;

  localparam int unsigned W = 8;
  localparam int unsigned D = 5;
  localparam int unsigned C = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   clr, vi, gi, go, vo, af, ae;
  logic [W-1:0] di [2];
  logic [W-1:0] dout [2];
  logic [C-1:0] cnt [2];
  logic [C-1:0] aft, aet;

  int vectors = 0;
  int miscompares = 0;
  int mcnt [2];
  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];

  typedef struct {
    logic         vi;
    logic [W-1:0] di;
    logic         gi;
    logic         clr;
    int           exp_cnt;
    logic         exp_grant;
    logic         exp_valid;
  } vec_t;
  vec_t tbl [12];

  always #5 clk = ~clk;

  generic_fifo_lvl #(.DATA_WIDTH(W), .DATA_DEPTH(D), .FALL_THROUGH(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear_i(clr[0]), .data_i(di[0]), .valid_i(vi[0]),
    .grant_o(go[0]), .data_o(dout[0]), .valid_o(vo[0]), .grant_i(gi[0]),
    .alm_full_thr_i(aft), .alm_empty_thr_i(aet), .count_o(cnt[0]),
    .alm_full_o(af[0]), .alm_empty_o(ae[0])
  );

  generic_fifo_lvl #(.DATA_WIDTH(W), .DATA_DEPTH(D), .FALL_THROUGH(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear_i(clr[1]), .data_i(di[1]), .valid_i(vi[1]),
    .grant_o(go[1]), .data_o(dout[1]), .valid_o(vo[1]), .grant_i(gi[1]),
    .alm_full_thr_i(aft), .alm_empty_thr_i(aet), .count_o(cnt[1]),
    .alm_full_o(af[1]), .alm_empty_o(ae[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] q_front(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  // One cycle on FIFO k (other FIFO idles): drive, check at negedge, update model.
  task automatic cyc(input int k, input logic v, input logic [W-1:0] d, input logic g,
                     input logic c);
    logic eg, ev, byp, ft;
    int   o;
    o = 1 - k;
    vi[o] = 1'b0; gi[o] = 1'b0; clr[o] = 1'b0;
    vi[k] = v; di[k] = d; gi[k] = g; clr[k] = c;
    @(negedge clk);
    ft = (k == 1);
    eg = !c && (mcnt[k] != D);
    ev = !c && ((mcnt[k] != 0) || (ft && v));
    check($sformatf("grant%0d", k), {31'b0, go[k]}, {31'b0, eg});
    check($sformatf("valid%0d", k), {31'b0, vo[k]}, {31'b0, ev});
    check($sformatf("count%0d", k), {29'b0, cnt[k]}, mcnt[k]);
    check($sformatf("almfull%0d", k), {31'b0, af[k]}, {31'b0, mcnt[k] >= int'(aft)});
    check($sformatf("almempty%0d", k), {31'b0, ae[k]}, {31'b0, mcnt[k] <= int'(aet)});
    if (ev) check($sformatf("data%0d", k), {24'b0, dout[k]},
                  {24'b0, (mcnt[k] == 0) ? d : q_front(k)});
    byp = ev && g && (mcnt[k] == 0);
    if (ev && g && !byp) begin
      if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      mcnt[k]--;
    end
    if (v && eg && !byp) begin
      if (k == 0) q0.push_back(d); else q1.push_back(d);
      mcnt[k]++;
    end
    if (c) begin
      mcnt[k] = 0;
      if (k == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic model_reset();
    mcnt[0] = 0; mcnt[1] = 0;
    q0.delete(); q1.delete();
  endtask

  initial begin
    for (int i = 0; i < 12; i++) begin
      if (i < 5) tbl[i] = '{1'b1, W'(i + 1), 1'b0, 1'b0, i, 1'b1, i != 0};
      else if (i == 5) tbl[i] = '{1'b1, 8'h63, 1'b0, 1'b0, 5, 1'b0, 1'b1};
      else if (i < 11) tbl[i] = '{1'b0, 8'h00, 1'b1, 1'b0, 11 - i, i != 6, 1'b1};
      else tbl[i] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0};
    end
    model_reset();
    clr = '0; vi = 2'b10; gi = '0; di[0] = 8'h11; di[1] = 8'h5A;
    aft = 3'd0; aet = 3'd1;
    #2;
    // Reset state, including the fall-through view of data_i.
    check("rst_grant0", {31'b0, go[0]}, 1);
    check("rst_valid0", {31'b0, vo[0]}, 0);
    check("rst_count0", {29'b0, cnt[0]}, 0);
    check("rst_data0", {24'b0, dout[0]}, 0);
    check("rst_ae0", {31'b0, ae[0]}, 1);
    check("rst_af0_thr0", {31'b0, af[0]}, 1);
    check("rst_valid1", {31'b0, vo[1]}, 1);
    check("rst_data1", {24'b0, dout[1]}, 32'h5A);
    aft = 3'd4;
    #1;
    check("rst_af0_thr4", {31'b0, af[0]}, 0);
    vi = '0;
    #9 rst_n = 1'b1;
    tick();

    // Fill to full with grant_i low, then drain in order.
    for (int i = 0; i < 12; i++) begin
      cyc(0, tbl[i].vi, tbl[i].di, tbl[i].gi, tbl[i].clr);
      check("tbl_cnt", {29'b0, cnt[0]}, tbl[i].exp_cnt);
      check("tbl_grant", {31'b0, go[0]}, {31'b0, tbl[i].exp_grant});
      check("tbl_valid", {31'b0, vo[0]}, {31'b0, tbl[i].exp_valid});
      tick();
    end

    // Sustained push+pop at level 2 across pointer wrap.
    cyc(0, 1'b1, 8'd10, 1'b0, 1'b0); tick();
    cyc(0, 1'b1, 8'd11, 1'b0, 1'b0); tick();
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1'b1, W'(12 + i), 1'b1, 1'b0);
      check("stream_head", {24'b0, dout[0]}, 10 + i);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1'b0, 8'h00, 1'b1, 1'b0); tick();
    end

    // Fall-through bypass, then a held fall-through entry.
    cyc(1, 1'b1, 8'hA5, 1'b1, 1'b0);
    check("ft_bypass_data", {24'b0, dout[1]}, 32'hA5);
    tick();
    cyc(1, 1'b1, 8'hA5, 1'b0, 1'b0); tick();
    cyc(1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("ft_hold_cnt", {29'b0, cnt[1]}, 1);
    check("ft_hold_data", {24'b0, dout[1]}, 32'hA5);
    tick();
    cyc(1, 1'b0, 8'h00, 1'b1, 1'b0); tick();

    // Clear at level 3 with a simultaneous push and pop request.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1'b1, W'(8'h40 + i), 1'b0, 1'b0); tick();
    end
    cyc(0, 1'b1, 8'h77, 1'b1, 1'b1);
    check("clr_grant", {31'b0, go[0]}, 0);
    check("clr_valid", {31'b0, vo[0]}, 0);
    tick();
    cyc(0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("clr_cnt", {29'b0, cnt[0]}, 0);
    tick();
    cyc(1, 1'b1, 8'h12, 1'b1, 1'b1); tick();

    // Thresholds that pin both flags high.
    aft = 3'd0; aet = 3'd7;
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1'b1, W'(i), 1'b0, 1'b0); tick();
    end
    aft = 3'd4; aet = 3'd1;

    // Randomised mix on both FIFOs.
    for (int i = 0; i < 120; i++) begin
      int k;
      k = int'($urandom_range(0, 1));
      cyc(k, 1'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
      tick();
    end

    // Asynchronous reset mid-stream.
    cyc(1, 1'b1, 8'h21, 1'b0, 1'b0); tick();
    vi[1] = 1'b1; di[1] = 8'h3C; gi[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_grant0", {31'b0, go[0]}, 1);
    check("arst_valid0", {31'b0, vo[0]}, 0);
    check("arst_count0", {29'b0, cnt[0]}, 0);
    check("arst_data0", {24'b0, dout[0]}, 0);
    check("arst_ae0", {31'b0, ae[0]}, 1);
    check("arst_count1", {29'b0, cnt[1]}, 0);
    check("arst_data1", {24'b0, dout[1]}, 32'h3C);
    check("arst_valid1", {31'b0, vo[1]}, 1);
    vi[1] = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1'b1, W'(8'h80 + i), i[0], 1'b0); tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/generic_fifo_lvl.md
# generic_fifo_lvl

Parametrised valid/grant FIFO: the next generation of the team's generic FIFO. Supports any depth (not only powers of two), an optional fall-through mode, a live fill-level output and run-time programmable almost-full/almost-empty flags. It sits between producer and consumer stages that use the valid/grant handshake and need back-pressure hints before the FIFO is actually full or empty.

## Interface
- DATA_WIDTH, 32: payload width, >= 1.
- DATA_DEPTH, 8: number of entries, >= 2, any integer.
- FALL_THROUGH, 0: 1 means an empty FIFO forwards data_i to data_o in the same cycle.
- CNT_WIDTH, $clog2(DATA_DEPTH+1): derived; width of the level and threshold signals.
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous flush.
- data_i  in  DATA_WIDTH  push data.
- valid_i  in  1  push request.
- grant_o  out  1  push accepted when valid_i && grant_o.
- data_o  out  DATA_WIDTH  head-of-queue data.
- valid_o  out  1  data_o valid.
- grant_i  in  1  pop accepted when valid_o && grant_i.
- alm_full_thr_i  in  CNT_WIDTH  almost-full threshold (quasi-static).
- alm_empty_thr_i  in  CNT_WIDTH  almost-empty threshold (quasi-static).
- count_o  out  CNT_WIDTH  current number of stored entries.
- alm_full_o  out  1  count_o >= alm_full_thr_i.
- alm_empty_o  out  1  count_o <= alm_empty_thr_i.

## Operation
- State:
  - registered push pointer, pop pointer and count, each reset to 0;
  - storage array, reset to all zeros.
  - Full/empty derive from count only (count == DATA_DEPTH / count == 0); no pointer-equality ambiguity.
- Pointers wrap explicitly: a pointer equal to DATA_DEPTH-1 advances to 0. Arithmetic is never modulo 2^n, so non-power-of-two depths are exact.
- Handshake signals:
  - grant_o = !clear_i && (count != DATA_DEPTH).
  - valid_o = !clear_i && (count != 0 || (FALL_THROUGH && valid_i)).
  - Neither depends on grant_i; no combinational path from grant_i to grant_o.
- Per-cycle action (push = valid_i && grant_o, pop = valid_o && grant_i):
  - push only: write storage[push_ptr], advance push_ptr, count+1.
  - pop only: advance pop_ptr, count-1.
  - push and pop, count != 0: both happen, count unchanged.
  - push and pop, count == 0 (only possible with FALL_THROUGH): data bypasses; no write, pointers and count unchanged.
  - neither: hold all state. Storage is written only on push, and not on bypass.
- data_o:
  - storage[pop_ptr] when count != 0.
  - data_i when count == 0 and FALL_THROUGH = 1.
  - storage[pop_ptr] (stale/reset data, don't-care) otherwise.
- clear_i: pointers and count go to 0 at the next edge. Clear has priority over any push or pop in that cycle; grant_o and valid_o are forced low so no transfer is lost silently. Storage contents are not cleared.
- Flags are combinational from the registered count and the threshold inputs. A threshold of 0 makes alm_full_o constant 1. A threshold >= DATA_DEPTH makes alm_empty_o constant 1.

## Timing
- Reset values: grant_o=1, valid_o=0 (FALL_THROUGH=1: valid_o follows valid_i), count_o=0, alm_empty_o=1, alm_full_o=(alm_full_thr_i==0), data_o=0 (FALL_THROUGH=1: data_i).
- Reset mid-operation discards all entries immediately and asynchronously.
- Latency, FALL_THROUGH=0: data pushed at edge N is visible on data_o with valid_o=1 in the cycle after edge N; minimum 1 cycle.
- Latency, FALL_THROUGH=1: 0 cycles when empty; otherwise as above.
- Full: grant_o=0. A simultaneous pop does not enable a push in that cycle; grant_o rises the cycle after the pop.
- Empty with FALL_THROUGH=0: valid_o=0. A simultaneous push is visible next cycle.
- count_o, alm_full_o and alm_empty_o update one cycle after the accepted transfer.
- Throughput: one push and one pop per cycle, sustained, at any fill level except full (push blocked) and empty in non-fall-through mode (pop blocked).

## Test plan
- DATA_DEPTH=5, FALL_THROUGH=0: push 1..5 with grant_i=0 -> grant_o drops after 5th push, count_o=5. Pop all -> data_o sequence 1,2,3,4,5, then valid_o=0 and count_o=0.
- DATA_DEPTH=5: 20 cycles of continuous push+pop at count=2 with values 10..29 -> in-order output with no gaps, count_o stays 2, pointers wrap 4->0 without data loss.
- FALL_THROUGH=1, empty, valid_i=1, data_i=0xA5, grant_i=1 -> valid_o=1 and data_o=0xA5 in the same cycle, count_o stays 0. Repeat with grant_i=0 -> count_o=1 next cycle and data_o holds 0xA5.
- alm_full_thr_i=4, alm_empty_thr_i=1, DATA_DEPTH=5: fill from 0 to 5 -> alm_empty_o=1 at counts 0-1, alm_full_o=1 at counts 4-5. Thresholds 0 and 7 -> both flags constant 1.
- Count=3, then clear_i=1 with valid_i=1 and grant_i=1 -> grant_o=0 and valid_o=0 that cycle; next cycle count_o=0 and no write occurred. rst_n pulsed low mid-stream -> all outputs at reset values immediately.
